// File: rtl/game_ctrl_pkg.sv
// Shared types and constants for the game sequencer.
// Holds the sequencer state enum, the button index map used to pack the
// six board buttons into one vector, and the LFSR feedback mask and step.
package game_ctrl_pkg;

  typedef enum logic [1:0] {
    MENU   = 2'd0,
    LAUNCH = 2'd1,
    PLAY   = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam int NUM_BTN    = 6;
  localparam int BTN_LEFT   = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_SINIST = 2;
  localparam int BTN_DEXTER = 3;
  localparam int BTN_ESC    = 4;
  localparam int BTN_ENTER  = 5;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // One right shift of the Galois LFSR; the mask is applied when a 1 drops out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] value);
    return (value >> 1) ^ (value[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/game_select_ctrl_btn_edge.sv
// Per-button conditioning: optional two-flop synchronizer, then a
// previous-value register to produce a one-cycle rising-edge strobe.
// Build option: INPUT_SYNC_EN inserts the synchronizer (adds 2 cycles).
module btn_edge (
  input  logic Clock,
  input  logic Resetn,
  input  logic raw,
  output logic level,
  output logic rise
);

`ifdef INPUT_SYNC_EN
  logic sync1_reg;
  logic sync2_reg;

  // Two-flop synchronizer for an asynchronous board button.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  assign level = sync2_reg;
`else
  assign level = raw;
`endif

  logic prev_reg;

  // Remember last cycle's level so a press is reported exactly once.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) prev_reg <= 1'b0;
    else         prev_reg <= level;
  end

  assign rise = level & ~prev_reg;

endmodule

// File: rtl/game_select_ctrl.sv
// Top-level game sequencer: menu cursor, launch/play/drain FSM, shared
// button forwarding, shared random source and VGA colour mux.
// Build option: INPUT_SYNC_EN (see btn_edge) synchronizes all six buttons.
module game_select_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int          NUM_GAMES = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          HOLDOFF   = 1024,
  localparam int         CW        = $clog2(NUM_GAMES)
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 Left,
  input  logic                 Right,
  input  logic                 Sinist,
  input  logic                 Dexter,
  input  logic                 Esc,
  input  logic                 Enter,
  input  logic [NUM_GAMES-1:0] GameQuit,
  input  logic [NUM_GAMES-1:0] GameCol,
  input  logic                 MenuCol,
  output logic [NUM_GAMES-1:0] GameEnable,
  output logic                 GLeft,
  output logic                 GRight,
  output logic                 GSinist,
  output logic                 GDexter,
  output logic                 GEsc,
  output logic                 GEnter,
  output logic [15:0]          Rand,
  output logic [CW-1:0]        Cursor,
  output logic                 InMenu,
  output logic                 VGAcol
);

  localparam int                DCW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [DCW-1:0]    DRAIN_LOAD = DCW'(HOLDOFF - 1);
  localparam logic [CW-1:0]     CURSOR_MAX = CW'(NUM_GAMES - 1);

  logic [NUM_BTN-1:0]   btn_raw;
  logic [NUM_BTN-1:0]   btn_level;
  logic [NUM_BTN-1:0]   btn_rise;

  state_t               state_reg;
  logic [CW-1:0]        cursor_reg;
  logic [NUM_GAMES-1:0] enable_reg;
  logic [NUM_BTN-1:0]   gbtn_reg;
  logic [DCW-1:0]       drain_reg;
  logic [15:0]          rand_reg;
  logic [CW-1:0]        cursor_left_next;
  logic [CW-1:0]        cursor_right_next;

  assign btn_raw = {Enter, Esc, Dexter, Sinist, Right, Left};

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_edge u_btn_edge (
        .Clock  (Clock),
        .Resetn (Resetn),
        .raw    (btn_raw[gi]),
        .level  (btn_level[gi]),
        .rise   (btn_rise[gi])
      );
    end
  endgenerate

  // Only the menu-navigation edges are consumed; the strike/Esc edges are not.
  logic unused_rise;
  assign unused_rise = ^{btn_rise[BTN_SINIST], btn_rise[BTN_DEXTER], btn_rise[BTN_ESC]};

  // Wrapping neighbours of the cursor, explicit so non-power-of-two counts work.
  always_comb begin
    cursor_left_next  = (cursor_reg == '0) ? CURSOR_MAX : cursor_reg - CW'(1);
    cursor_right_next = (cursor_reg == CURSOR_MAX) ? '0 : cursor_reg + CW'(1);
  end

  // Sequencer FSM with registered enable, forwarded buttons, cursor and drain timer.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg  <= MENU;
      cursor_reg <= '0;
      enable_reg <= '0;
      gbtn_reg   <= '0;
      drain_reg  <= '0;
    end else begin
      case (state_reg)
        MENU: begin
          gbtn_reg <= '0;
          if (btn_rise[BTN_ENTER]) begin
            // Enter wins over a same-cycle move so the launched core is the highlighted one.
            state_reg  <= LAUNCH;
            enable_reg <= NUM_GAMES'(1) << cursor_reg;
          end else if (btn_rise[BTN_LEFT] && !btn_rise[BTN_RIGHT]) begin
            cursor_reg <= cursor_left_next;
          end else if (btn_rise[BTN_RIGHT] && !btn_rise[BTN_LEFT]) begin
            cursor_reg <= cursor_right_next;
          end
        end
        LAUNCH: begin
          // Keep the core's buttons quiet until the launching press is fully released.
          gbtn_reg <= '0;
          if (btn_level == '0) state_reg <= PLAY;
        end
        PLAY: begin
          if (GameQuit[cursor_reg]) begin
            state_reg  <= DRAIN;
            enable_reg <= '0;
            gbtn_reg   <= '0;
            drain_reg  <= DRAIN_LOAD;
          end else begin
            gbtn_reg <= btn_level;
          end
        end
        DRAIN: begin
          enable_reg <= '0;
          gbtn_reg   <= '0;
          if (drain_reg == '0) begin
            // A held Esc pins us here so the game's own quit key cannot leak into the menu.
            if (!btn_level[BTN_ESC]) state_reg <= MENU;
          end else begin
            drain_reg <= drain_reg - DCW'(1);
          end
        end
        default: state_reg <= MENU;
      endcase
    end
  end

  // Free-running shared random source, stepped every cycle in every state.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) rand_reg <= LFSR_SEED;
    else         rand_reg <= lfsr_next(rand_reg);
  end

  assign GameEnable = enable_reg;
  assign GLeft      = gbtn_reg[BTN_LEFT];
  assign GRight     = gbtn_reg[BTN_RIGHT];
  assign GSinist    = gbtn_reg[BTN_SINIST];
  assign GDexter    = gbtn_reg[BTN_DEXTER];
  assign GEsc       = gbtn_reg[BTN_ESC];
  assign GEnter     = gbtn_reg[BTN_ENTER];
  assign Rand       = rand_reg;
  assign Cursor     = cursor_reg;
  assign InMenu     = (state_reg == MENU) || (state_reg == DRAIN);
  assign VGAcol     = ((state_reg == LAUNCH) || (state_reg == PLAY)) ? GameCol[cursor_reg] : MenuCol;

endmodule

// File: tb/tb_game_select_ctrl.sv
// Self-checking bench for game_select_ctrl (NUM_GAMES=4, HOLDOFF=8).
// A behavioural model predicts every output each cycle; directed literal
// checks pin cursor walks, launch, forwarding, drain timing, LFSR period
// and asynchronous reset. Honours INPUT_SYNC_EN for button latency.
module tb_game_select_ctrl;

  localparam int          N     = 4;
  localparam int          HOLD  = 8;
  localparam logic [15:0] SEED  = 16'hACE1;
`ifdef INPUT_SYNC_EN
  localparam int          SYNC  = 2;
`else
  localparam int          SYNC  = 0;
`endif
  localparam int          LAT   = 1 + SYNC;

  logic         Clock;
  logic         Resetn;
  logic [5:0]   btn;        // {Enter, Esc, Dexter, Sinist, Right, Left}
  logic [N-1:0] GameQuit;
  logic [N-1:0] GameCol;
  logic         MenuCol;
  logic [N-1:0] GameEnable;
  logic         GLeft, GRight, GSinist, GDexter, GEsc, GEnter;
  logic [15:0]  Rand;
  logic [1:0]   Cursor;
  logic         InMenu;
  logic         VGAcol;

  int total = 0;
  int bad   = 0;

  game_select_ctrl #(.NUM_GAMES(N), .LFSR_SEED(SEED), .HOLDOFF(HOLD)) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Left       (btn[0]),
    .Right      (btn[1]),
    .Sinist     (btn[2]),
    .Dexter     (btn[3]),
    .Esc        (btn[4]),
    .Enter      (btn[5]),
    .GameQuit   (GameQuit),
    .GameCol    (GameCol),
    .MenuCol    (MenuCol),
    .GameEnable (GameEnable),
    .GLeft      (GLeft),
    .GRight     (GRight),
    .GSinist    (GSinist),
    .GDexter    (GDexter),
    .GEsc       (GEsc),
    .GEnter     (GEnter),
    .Rand       (Rand),
    .Cursor     (Cursor),
    .InMenu     (InMenu),
    .VGAcol     (VGAcol)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- behavioural model ----------------
  localparam int M_MENU = 0, M_LAUNCH = 1, M_PLAY = 2, M_DRAIN = 3;
  int          m_mode    = M_MENU;
  int          m_cursor  = 0;
  int          m_elapsed = 0;
  logic [5:0]  m_g       = '0;
  logic [15:0] m_rand    = SEED;
  logic [5:0]  m_prev    = '0;
  logic [5:0]  m_d1      = '0;
  logic [5:0]  m_d2      = '0;

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      m_mode = M_MENU; m_cursor = 0; m_elapsed = 0; m_g = '0;
      m_rand = SEED; m_prev = '0; m_d1 = '0; m_d2 = '0;
    end else begin
      logic [5:0] seen;
      logic [5:0] rise;
      int         old_mode;
      seen = (SYNC != 0) ? m_d2 : btn;
      m_d2 = m_d1;
      m_d1 = btn;
      rise = seen & ~m_prev;
      m_prev = seen;
      old_mode = m_mode;
      case (m_mode)
        M_MENU: begin
          if (rise[5]) m_mode = M_LAUNCH;
          else if (rise[0] && !rise[1]) m_cursor = (m_cursor + N - 1) % N;
          else if (rise[1] && !rise[0]) m_cursor = (m_cursor + 1) % N;
        end
        M_LAUNCH: if (seen == 6'b0) m_mode = M_PLAY;
        M_PLAY: if (GameQuit[m_cursor]) begin m_mode = M_DRAIN; m_elapsed = 0; end
        default: begin
          if (m_elapsed >= HOLD - 1 && !seen[4]) m_mode = M_MENU;
          else m_elapsed++;
        end
      endcase
      m_g = (old_mode == M_PLAY && m_mode == M_PLAY) ? seen : 6'b0;
      m_rand = {1'b0, m_rand[15:1]} ^ (m_rand[0] ? 16'hB400 : 16'h0000);
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      logic [N-1:0] e_en;
      logic         e_in, e_vga;
      logic [5:0]   a_g;
      @(negedge Clock);
      #1;
      e_en  = (m_mode == M_LAUNCH || m_mode == M_PLAY) ? (N'(1) << m_cursor) : '0;
      e_in  = (m_mode == M_MENU || m_mode == M_DRAIN);
      e_vga = (m_mode == M_LAUNCH || m_mode == M_PLAY) ? GameCol[m_cursor] : MenuCol;
      a_g   = {GEnter, GEsc, GDexter, GSinist, GRight, GLeft};
      total++;
      if (Cursor !== 2'(m_cursor) || GameEnable !== e_en || a_g !== m_g || InMenu !== e_in ||
          VGAcol !== e_vga || Rand !== m_rand) begin
        bad++;
        $display("FAIL cycle t=%0t got/req cursor=%0d/%0d en=%b/%b g=%b/%b inmenu=%b/%b vga=%b/%b rand=%h/%h",
                 $time, Cursor, m_cursor, GameEnable, e_en, a_g, m_g, InMenu, e_in, VGAcol, e_vga, Rand, m_rand);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic pulse(input logic [5:0] mask);
    btn = mask;
    @(negedge Clock);
    btn = '0;
    repeat (1 + SYNC) @(negedge Clock);
  endtask

  task automatic launch_to_play();
    btn = 6'b100000;
    @(negedge Clock);
    btn = '0;
    repeat (3 + SYNC) @(negedge Clock);
  endtask

  int         right_exp [5] = '{1, 2, 3, 0, 1};
  int         left_exp  [2] = '{0, 3};
  logic       zero_seen;

  initial begin
    Resetn = 1'b0; btn = '0; GameQuit = '0; GameCol = '0; MenuCol = 1'b0;
    repeat (3) @(negedge Clock);
    chk("reset_cursor", 32'(Cursor), 0);
    chk("reset_enable", 32'(GameEnable), 0);
    chk("reset_inmenu", 32'(InMenu), 1);
    chk("reset_rand", 32'(Rand), 32'hACE1);
    chk("reset_gbtn", 32'({GEnter, GEsc, GDexter, GSinist, GRight, GLeft}), 0);

    // LFSR full period from the seed.
    Resetn = 1'b1;
    zero_seen = 1'b0;
    for (int k = 1; k <= 65535; k++) begin
      @(negedge Clock);
      if (Rand == 16'h0) zero_seen = 1'b1;
      if (k == 1) chk("rand_step1", 32'(Rand), 32'hE270);
    end
    chk("rand_period", 32'(Rand), 32'hACE1);
    chk("rand_nonzero", 32'(zero_seen), 0);

    // Cursor walks with wrap.
    for (int i = 0; i < 5; i++) begin
      pulse(6'b000010);
      chk($sformatf("right_%0d", i), 32'(Cursor), 32'(right_exp[i]));
    end
    for (int i = 0; i < 2; i++) begin
      pulse(6'b000001);
      chk($sformatf("left_%0d", i), 32'(Cursor), 32'(left_exp[i]));
    end
    pulse(6'b000001);
    chk("cursor_to_2", 32'(Cursor), 2);
    pulse(6'b000011);
    chk("left_right_same", 32'(Cursor), 2);

    // Launch core 2 with a same-cycle Right that must be ignored.
    GameCol = 4'b0100;
    btn = 6'b100010;
    @(negedge Clock);
    btn = 6'b100000;
    repeat (SYNC) @(negedge Clock);
    chk("launch_enable", 32'(GameEnable), 32'h4);
    chk("launch_cursor", 32'(Cursor), 2);
    chk("launch_inmenu", 32'(InMenu), 0);
    chk("launch_vga", 32'(VGAcol), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk($sformatf("enter_held_%0d", i), 32'(GEnter), 0);
    end
    btn = '0;
    repeat (2 + SYNC) @(negedge Clock);
    chk("play_genter", 32'(GEnter), 0);

    // Strike forwarding latency.
    btn = 6'b000100;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge Clock);
      chk($sformatf("sinist_lat_%0d", i), 32'(GSinist), (i == LAT) ? 1 : 0);
    end
    btn = '0;
    repeat (LAT + 1) @(negedge Clock);

    // Quit from an unselected core, then from the selected one.
    GameQuit = 4'b0001;
    @(negedge Clock);
    GameQuit = '0;
    chk("quit_other", 32'(GameEnable), 32'h4);
    GameQuit = 4'b0100;
    @(negedge Clock);
    GameQuit = '0;
    chk("quit_enable", 32'(GameEnable), 0);
    chk("quit_inmenu", 32'(InMenu), 1);
    chk("quit_vga", 32'(VGAcol), 0);
    // Left lands on the last DRAIN edge (ignored), Right on the first MENU edge.
    repeat (HOLD - 1 - SYNC) @(negedge Clock);
    btn = 6'b000001;
    @(negedge Clock);
    btn = 6'b000010;
    @(negedge Clock);
    btn = '0;
    repeat (SYNC) @(negedge Clock);
    chk("drain_boundary", 32'(Cursor), 3);
    pulse(6'b000001);
    chk("back_to_2", 32'(Cursor), 2);

    // Esc held over the drain boundary.
    launch_to_play();
    chk("relaunch_enable", 32'(GameEnable), 32'h4);
    btn = 6'b010000;
    repeat (2) @(negedge Clock);
    GameQuit = 4'b0100;
    @(negedge Clock);
    GameQuit = '0;
    chk("esc_quit_enable", 32'(GameEnable), 0);
    repeat (HOLD + 4) @(negedge Clock);
    btn = 6'b010001;
    @(negedge Clock);
    btn = 6'b010000;
    repeat (1 + SYNC) @(negedge Clock);
    chk("esc_hold_stays", 32'(Cursor), 2);
    btn = 6'b000001;
    @(negedge Clock);
    btn = 6'b000010;
    @(negedge Clock);
    btn = '0;
    repeat (SYNC) @(negedge Clock);
    chk("esc_release_menu", 32'(Cursor), 3);

    // Asynchronous reset in the middle of play on core 3.
    launch_to_play();
    GameCol = 4'b0000;
    MenuCol = 1'b1;
    #1;
    chk("play3_enable", 32'(GameEnable), 32'h8);
    chk("play3_vga", 32'(VGAcol), 0);
    #1 Resetn = 1'b0;
    #1;
    chk("areset_enable", 32'(GameEnable), 0);
    chk("areset_cursor", 32'(Cursor), 0);
    chk("areset_vga", 32'(VGAcol), 1);
    chk("areset_inmenu", 32'(InMenu), 1);
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
